id_token_tracker: RTL and testbench
===================================

// Module: id_token_tracker
// PURPOSE
// - Sits directly downstream of the identifier-recognizer FSM.
// - Watches the char stream and the recognizer's per-char hit flag, and delimits each identifier run.
// - Pushes one token record {length[, hash]} per run into a small FIFO, read out over a valid/ready port.
// - Keeps a running token count and a sticky overflow flag.
// PARAMETERS
// - LEN_W  6   width of token length; length saturates at 2**LEN_W-1
// - DEPTH  4   FIFO entries, power of 2, >=2
// - CNT_W  16  width of token counter; wraps modulo 2**CNT_W
// PORTS
// - clk        in   1      system clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - char       in   8      ASCII char of current cycle, qualified by id_hit
// - id_hit     in   1      1 = char belongs to identifier run (recognizer out, aligned with char by upstream)
// - flush      in   1      force-close any open run this cycle
// - tok_ready  in   1      consumer accepts head record
// - tok_valid  out  1      FIFO non-empty
// - tok_len    out  LEN_W  head record length
// - tok_hash   out  8      head record hash (0 when TOKEN_HASH_EN undefined)
// - tok_count  out  CNT_W  total records pushed since reset
// - overflow   out  1      sticky: a record was dropped because FIFO full
// - busy       out  1      run currently open (state == IN_ID)
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=IDLE; len=0; hash=0; FIFO empty.
//   - tok_valid=0, tok_len=0, tok_hash=0, tok_count=0, overflow=0, busy=0.
// - FSM, evaluated each rising clk:
//   - IDLE & id_hit=1 -> IN_ID; len<=1; hash<=char.
//   - IDLE & id_hit=0 -> stay; flush is a no-op.
//   - IN_ID & id_hit=1 & !flush -> stay; len<=sat(len+1); hash<=rotl1(hash)^char.
//   - IN_ID & (id_hit=0 | flush) -> push {len,hash} and go to IDLE.
//     - The closing cycle's char is not part of the token.
//   - IN_ID & flush & id_hit=1 -> push the old run, then open a new run: len<=1, hash<=char.
// - Length saturation: len holds at 2**LEN_W-1. The hash keeps updating.
// - Push/pop:
//   - Pop occurs when tok_valid & tok_ready.
//   - A record pushed at edge N is visible as tok_valid=1 after edge N (1-cycle latency).
//   - Outputs show the FIFO head combinationally from registered storage.
//   - Full & push & pop in the same cycle: the push is accepted and the count stays DEPTH.
//   - Full & push & no pop: the record is dropped, overflow<=1, and tok_count still increments.
//   - Empty & pop attempt: ignored (tok_valid=0).
// - tok_count increments on every close event, whether accepted or dropped. It wraps at 2**CNT_W.
// - Pointers: log2(DEPTH)+1 bits; wrap-around handled by the MSB compare.
// - rst mid-run: the open run is discarded and no record is pushed.
// CONFIGURATION
// - TOKEN_HASH_EN defined:
//   - An 8-bit hash register is built and stored per FIFO entry.
//   - tok_hash = head hash.
// - TOKEN_HASH_EN undefined:
//   - No hash register or storage.
//   - tok_hash tied to 8'h00.
//   - All other behaviour is identical.
// TESTING
// - Reset: hold rst=1 with random char/id_hit -> all outputs 0. Release -> stay 0 while id_hit=0.
// - Run "abcd": chars 8'h61..8'h64 with id_hit=1 for 4 cycles, then id_hit=0.
//   - tok_valid=1 one cycle after close; tok_len=4; tok_count=1; busy falls.
//   - tok_hash=8'h20 (hash enabled) or 8'h00 (hash disabled).
// - Fill: tok_ready=0, five 1-char runs, DEPTH=4.
//   - Four records held; overflow=1 after the 5th close; tok_count=5.
//   - Drain gives len=1 x4, then tok_valid=0.
// - Full plus simultaneous pop: FIFO full, tok_ready=1 in the same cycle as a close.
//   - overflow stays 0; the new record is last out; occupancy remains 4.
// - Saturation: id_hit=1 for 70 cycles with LEN_W=6 -> tok_len=63.
// - Flush: flush=1 with id_hit=1 mid-run of 3.
//   - Record len=3 is pushed, then a new run starts.
//   - Closing it after 2 more hits gives a second record, len=3 (1+2).
//   - rst during a run gives tok_valid=0 and tok_count=0.

Source files
------------

// File: rtl/id_token_tracker_if.sv
// Token-tracker port bundle: recognizer char stream in, token-record valid/ready port out.
// The slave modport is the tracker; master is whoever drives the char stream and drains records.
interface id_token_tracker_if #(
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
);
    logic [7:0]       char;
    logic             id_hit;
    logic             flush;
    logic             tok_ready;
    logic             tok_valid;
    logic [LEN_W-1:0] tok_len;
    logic [7:0]       tok_hash;
    logic [CNT_W-1:0] tok_count;
    logic             overflow;
    logic             busy;

    modport slave (
        input  char, id_hit, flush, tok_ready,
        output tok_valid, tok_len, tok_hash, tok_count, overflow, busy
    );

    modport master (
        output char, id_hit, flush, tok_ready,
        input  tok_valid, tok_len, tok_hash, tok_count, overflow, busy
    );
endinterface

// File: rtl/id_token_tracker.sv
// Delimits identifier runs from the recognizer hit flag and queues one {len[,hash]} record per run.
// Records appear one cycle after the close edge; a full FIFO without a same-cycle pop drops the record (TOKEN_HASH_EN adds the hash).
module id_token_tracker #(
    parameter int LEN_W = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst,
    id_token_tracker_if.slave tk
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [PW:0]      PTR_ONE = (PW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE = 1'b0, IN_ID = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_mem_q [DEPTH];

    logic             close;
    logic             empty;
    logic             full;
    logic             pop;
    logic             accept;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;

    assign wr_idx = wr_ptr_q[PW-1:0];
    assign rd_idx = rd_ptr_q[PW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    // Same slot index with differing wrap bits means every entry is occupied.
    assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
    assign pop    = !empty && tk.tok_ready;
    assign close  = (state_q == IN_ID) && (!tk.id_hit || tk.flush);
    // A pop in the same cycle frees the slot the new record lands in.
    assign accept = close && (!full || pop);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (tk.id_hit) begin
                    state_d = IN_ID;
                    len_d   = LEN_ONE;
                end
            end
            IN_ID: begin
                if (tk.id_hit && tk.flush) begin
                    len_d = LEN_ONE;
                end else if (tk.id_hit) begin
                    len_d = (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;
                end else begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                len_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (close) begin
            count_d = count_q + CNT_ONE;
        end
        if (close && !accept) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                len_mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (accept) begin
                len_mem_q[wr_idx] <= len_q;
            end
        end
    end

`ifdef TOKEN_HASH_EN
    logic [7:0] hash_q, hash_d;
    logic [7:0] hash_mem_q [DEPTH];

    always_comb begin
        hash_d = hash_q;
        if (tk.id_hit && (state_q == IDLE || tk.flush)) begin
            hash_d = tk.char;
        end else if (tk.id_hit) begin
            hash_d = {hash_q[6:0], hash_q[7]} ^ tk.char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                hash_mem_q[i] <= '0;
            end
        end else begin
            hash_q <= hash_d;
            if (accept) begin
                hash_mem_q[wr_idx] <= hash_q;
            end
        end
    end

    assign tk.tok_hash = empty ? 8'h00 : hash_mem_q[rd_idx];
`else
    logic unused_char;
    assign unused_char = ^tk.char;
    assign tk.tok_hash = 8'h00;
`endif

    assign tk.tok_valid = !empty;
    assign tk.tok_len   = empty ? '0 : len_mem_q[rd_idx];
    assign tk.tok_count = count_q;
    assign tk.overflow  = ovf_q;
    assign tk.busy      = (state_q == IN_ID);
endmodule

// File: tb/tb_id_token_tracker.sv
// Directed bench for id_token_tracker: expected records are queued at issue time, a negedge monitor pops them on handshake.
module tb_id_token_tracker;
    localparam int LEN_W = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [7:0]       hash;
    } rec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    rec_t sb[$];

    id_token_tracker_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) tk ();

    id_token_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .tk  (tk)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] eh(input logic [7:0] h);
`ifdef TOKEN_HASH_EN
        return h;
`else
        return 8'h00 & h;
`endif
    endfunction

    task automatic sb_push(input logic [LEN_W-1:0] len, input logic [7:0] hash);
        rec_t r;
        r.len  = len;
        r.hash = eh(hash);
        sb.push_back(r);
    endtask

    task automatic cyc(input logic [7:0] c, input logic h, input logic f);
        tk.char   = c;
        tk.id_hit = h;
        tk.flush  = f;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted record must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && tk.tok_valid && tk.tok_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got len=%0d hash=%0h expected no record", tk.tok_len, tk.tok_hash);
            end else begin
                rec_t e;
                e = sb.pop_front();
                check("pop_len", 32'(tk.tok_len), 32'(e.len));
                check("pop_hash", 32'(tk.tok_hash), 32'(e.hash));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        tests = 0;
        fails = 0;
        tk.tok_ready = 1'b0;
        tk.flush     = 1'b0;
        tk.char      = 8'h00;
        tk.id_hit    = 1'b0;

        // Reset held with random input activity
        for (int i = 0; i < 4; i++) begin
            tk.char   = 8'($urandom);
            tk.id_hit = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rst_valid", 32'(tk.tok_valid), 0);
        check("rst_len", 32'(tk.tok_len), 0);
        check("rst_hash", 32'(tk.tok_hash), 0);
        check("rst_count", 32'(tk.tok_count), 0);
        check("rst_ovf", 32'(tk.overflow), 0);
        check("rst_busy", 32'(tk.busy), 0);
        rst = 1'b0;
        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        check("idle_valid", 32'(tk.tok_valid), 0);
        check("idle_busy", 32'(tk.busy), 0);
        check("idle_count", 32'(tk.tok_count), 0);

        // Run "abcd"
        cyc(8'h61, 1'b1, 1'b0);
        cyc(8'h62, 1'b1, 1'b0);
        cyc(8'h63, 1'b1, 1'b0);
        cyc(8'h64, 1'b1, 1'b0);
        check("abcd_busy_open", 32'(tk.busy), 1);
        check("abcd_valid_open", 32'(tk.tok_valid), 0);
        sb_push(6'd4, 8'h20);
        cyc(8'h00, 1'b0, 1'b0);
        check("abcd_valid", 32'(tk.tok_valid), 1);
        check("abcd_len", 32'(tk.tok_len), 4);
        check("abcd_hash", 32'(tk.tok_hash), 32'(eh(8'h20)));
        check("abcd_count", 32'(tk.tok_count), 1);
        check("abcd_busy", 32'(tk.busy), 0);
        tk.tok_ready = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        tk.tok_ready = 1'b0;
        check("abcd_drained", 32'(tk.tok_valid), 0);

        // Fill with five 1-char runs, consumer stalled
        for (int i = 0; i < 5; i++) begin
            cyc(8'h41 + 8'(i), 1'b1, 1'b0);
            if (i < DEPTH) sb_push(6'd1, 8'h41 + 8'(i));
            cyc(8'h00, 1'b0, 1'b0);
            if (i == DEPTH - 1) check("fill_ovf_before", 32'(tk.overflow), 0);
        end
        check("fill_ovf", 32'(tk.overflow), 1);
        check("fill_count", 32'(tk.tok_count), 6);
        check("fill_valid", 32'(tk.tok_valid), 1);
        tk.tok_ready = 1'b1;
        repeat (DEPTH) cyc(8'h00, 1'b0, 1'b0);
        tk.tok_ready = 1'b0;
        check("fill_empty", 32'(tk.tok_valid), 0);
        check("fill_ovf_sticky", 32'(tk.overflow), 1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_count", 32'(tk.tok_count), 0);
        check("rst2_ovf", 32'(tk.overflow), 0);

        // Full FIFO with a pop on the close edge
        for (int i = 0; i < DEPTH; i++) begin
            cyc(8'h51 + 8'(i), 1'b1, 1'b0);
            sb_push(6'd1, 8'h51 + 8'(i));
            cyc(8'h00, 1'b0, 1'b0);
        end
        cyc(8'h55, 1'b1, 1'b0);
        sb_push(6'd1, 8'h55);
        tk.tok_ready = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        tk.tok_ready = 1'b0;
        check("fullpop_ovf", 32'(tk.overflow), 0);
        check("fullpop_count", 32'(tk.tok_count), 5);
        tk.tok_ready = 1'b1;
        repeat (DEPTH - 1) cyc(8'h00, 1'b0, 1'b0);
        check("fullpop_occ_last", 32'(tk.tok_valid), 1);
        cyc(8'h00, 1'b0, 1'b0);
        check("fullpop_occ_empty", 32'(tk.tok_valid), 0);
        tk.tok_ready = 1'b0;

        // Length saturation: 70 hits, even count of 8'hFF leaves hash at 0
        repeat (70) cyc(8'hFF, 1'b1, 1'b0);
        check("sat_busy", 32'(tk.busy), 1);
        sb_push(6'd63, 8'h00);
        cyc(8'h00, 1'b0, 1'b0);
        check("sat_len", 32'(tk.tok_len), 63);
        tk.tok_ready = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        tk.tok_ready = 1'b0;
        check("sat_count", 32'(tk.tok_count), 6);

        // Flush mid-run with id_hit high
        cyc(8'h78, 1'b1, 1'b0);
        cyc(8'h79, 1'b1, 1'b0);
        cyc(8'h7A, 1'b1, 1'b0);
        sb_push(6'd3, 8'h69);
        cyc(8'h70, 1'b1, 1'b1);
        check("flush_busy", 32'(tk.busy), 1);
        check("flush_valid", 32'(tk.tok_valid), 1);
        check("flush_count", 32'(tk.tok_count), 7);
        cyc(8'h71, 1'b1, 1'b0);
        cyc(8'h72, 1'b1, 1'b0);
        sb_push(6'd3, 8'h51);
        cyc(8'h00, 1'b0, 1'b0);
        check("flush2_count", 32'(tk.tok_count), 8);
        cyc(8'h00, 1'b0, 1'b1);
        check("flush_idle_count", 32'(tk.tok_count), 8);
        check("flush_idle_busy", 32'(tk.busy), 0);
        tk.tok_ready = 1'b1;
        repeat (2) cyc(8'h00, 1'b0, 1'b0);
        tk.tok_ready = 1'b0;
        check("flush_drained", 32'(tk.tok_valid), 0);

        // Reset in the middle of a run, with a record already queued
        cyc(8'h33, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        check("midrst_pre_valid", 32'(tk.tok_valid), 1);
        cyc(8'h41, 1'b1, 1'b0);
        cyc(8'h42, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(tk.tok_valid), 0);
        check("midrst_count", 32'(tk.tok_count), 0);
        check("midrst_busy", 32'(tk.busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) cyc(8'h00, 1'b0, 1'b0);
        check("midrst_after_valid", 32'(tk.tok_valid), 0);
        check("midrst_after_count", 32'(tk.tok_count), 0);

        check("sb_leftover", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
